// File: rtl/div_unit_pkg.sv
// Shared execute-stage encodings for the iterative divider: div_op codes,
// handshake FSM states and small op-decode helpers.
package div_unit_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Bit 0 clear selects the signed flavour (DIV/REM).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 set selects the remainder (REM/REMU).
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_core.sv
// Unsigned restoring shift-subtract datapath, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst      clock, async active-high reset
//   start         load operands and begin LEN iterations
//   flush         abandon the running division
//   dividend      unsigned dividend (sampled on start)
//   divisor       unsigned divisor, non-zero (sampled on start)
//   done_c        high in the cycle whose edge completes the last iteration
//   quotient_c    quotient after the current iteration (final when done_c)
//   remainder_c   remainder after the current iteration (final when done_c)
module div_unit_core #(
    parameter int unsigned LEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           flush,
    input  logic [LEN-1:0] dividend,
    input  logic [LEN-1:0] divisor,
    output logic           done_c,
    output logic [LEN-1:0] quotient_c,
    output logic [LEN-1:0] remainder_c
);

    localparam int unsigned CW = $clog2(LEN);

    logic [LEN-1:0] rem_q, rem_d;
    logic [LEN-1:0] quo_q, quo_d;
    logic [LEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           run_q, run_d;

    // Trial remainder is one bit wider than the operands; its MSB is the borrow.
    logic [LEN:0]   trial_c;
    logic [LEN:0]   diff_c;
    logic           fits_c;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial_c     = {rem_q, quo_q[LEN-1]};
        diff_c      = trial_c - {1'b0, dvs_q};
        fits_c      = ~diff_c[LEN];
        remainder_c = fits_c ? diff_c[LEN-1:0] : trial_c[LEN-1:0];
        quotient_c  = {quo_q[LEN-2:0], fits_c};
        done_c      = run_q && (cnt_q == CW'(LEN - 1));
    end

    // Load / iterate / stop control.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (flush) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = remainder_c;
            quo_d = quotient_c;
            cnt_d = done_c ? '0 : cnt_q + CW'(1);
            run_d = ~done_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: request/response handshake FSM, special-case
// resolution at accept, operand sign handling around the unsigned core.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid / in_ready   request handshake (div_op, dividend, divisor)
//   flush                 pipeline kill, returns to IDLE
//   out_valid / out_ready response handshake (result)
//   busy                  high while an operation is in CALC or DONE
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned LEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     div_op,
    input  logic [LEN-1:0] dividend,
    input  logic [LEN-1:0] divisor,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LEN-1:0] result,
    output logic           busy
);

    localparam logic [LEN-1:0] MIN_VAL = {1'b1, {(LEN-1){1'b0}}};

    div_state_e     state_q, state_d;
    logic [LEN-1:0] result_q, result_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic           is_rem_q, is_rem_d;
    logic           neg_q, neg_d;

    logic           sgn_c, a_neg_c, b_neg_c, start_c;
    logic [LEN-1:0] a_abs_c, b_abs_c, sel_c;
    logic           core_done_c;
    logic [LEN-1:0] core_quo_c, core_rem_c;

    // Magnitudes for signed ops; the most negative value maps to 2^(LEN-1) unsigned.
    always_comb begin
        sgn_c   = op_is_signed(div_op);
        a_neg_c = sgn_c & dividend[LEN-1];
        b_neg_c = sgn_c & divisor[LEN-1];
        a_abs_c = a_neg_c ? ({LEN{1'b0}} - dividend) : dividend;
        b_abs_c = b_neg_c ? ({LEN{1'b0}} - divisor) : divisor;
    end

    div_unit_core #(.LEN(LEN)) u_core (
        .clk         (clk),
        .rst         (rst),
        .start       (start_c),
        .flush       (flush),
        .dividend    (a_abs_c),
        .divisor     (b_abs_c),
        .done_c      (core_done_c),
        .quotient_c  (core_quo_c),
        .remainder_c (core_rem_c)
    );

    assign sel_c = is_rem_q ? core_rem_c : core_quo_c;

    // Handshake FSM next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        is_rem_d = is_rem_q;
        neg_d    = neg_q;
        start_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    is_rem_d = op_is_rem(div_op);
                    // Remainder follows the dividend sign; quotient negates on sign mismatch.
                    neg_d    = op_is_rem(div_op) ? a_neg_c : (a_neg_c ^ b_neg_c);
                    if (divisor == '0) begin
                        result_d = op_is_rem(div_op) ? dividend : '1;
                        state_d  = ST_DONE;
                    end else if (sgn_c && (dividend == MIN_VAL) && (divisor == '1)) begin
                        result_d = op_is_rem(div_op) ? '0 : MIN_VAL;
                        state_d  = ST_DONE;
                    end else begin
                        start_c  = 1'b1;
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (core_done_c) begin
                    result_d = neg_q ? ({LEN{1'b0}} - sel_c) : sel_c;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            is_rem_q    <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            is_rem_q    <= is_rem_d;
            neg_q       <= neg_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (LEN=32): arithmetic reference model,
// per-cycle output monitor, directed corner cases and randomized operations.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int unsigned LEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      div_op;
    logic [LEN-1:0]  dividend;
    logic [LEN-1:0]  divisor;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [LEN-1:0]  result;
    logic            busy;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [LEN-1:0]  exp_cur  = '0;
    bit              saw_valid = 1'b0;

    div_unit #(.LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div_op    (div_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // RISC-V M-extension semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_DIV:  return 32'(sa / sb);
            OP_REM:  return 32'(sa % sb);
            OP_DIVU: return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LEN + 1;
    endfunction

    // Per-cycle monitor: held result must match, busy must mirror !in_ready.
    always @(negedge clk) begin
        if (!rst) begin
            check(busy == !in_ready, "busy_vs_in_ready", 32'(busy), 32'(!in_ready));
            if (out_valid) begin
                saw_valid <= 1'b1;
                check(result == exp_cur, "mon_result", result, exp_cur);
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        int lat;
        int req_lat;
        exp_cur = ref_div(op, a, b);
        req_lat = ref_lat(op, a, b);
        @(negedge clk);
        in_valid  = 1'b1;
        div_op    = op;
        dividend  = a;
        divisor   = b;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        div_op   = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
        check(in_ready == 1'b0, "accept_in_ready", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check(lat == req_lat, "latency", 32'(lat), 32'(req_lat));
        check(result == exp_cur, "result", result, exp_cur);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check(out_valid && !in_ready && result == exp_cur, "stall_hold", result, exp_cur);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check(!out_valid && in_ready, "resp_handshake", {30'd0, out_valid, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; div_op = 2'b00; dividend = '0; divisor = '0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        check(in_ready == 1'b1 && busy == 1'b0 && out_valid == 1'b0, "reset_flags",
              {29'd0, in_ready, busy, out_valid}, 32'd4);
        check(result == '0, "reset_result", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Hand-computed values pin the reference model.
        check(ref_div(OP_DIVU, 32'd100, 32'd7) == 32'd14, "model_divu", ref_div(OP_DIVU, 32'd100, 32'd7), 32'd14);
        check(ref_div(OP_REMU, 32'd100, 32'd7) == 32'd2, "model_remu", ref_div(OP_REMU, 32'd100, 32'd7), 32'd2);
        check(ref_div(OP_DIV, 32'hFFFF_FFF9, 32'd2) == 32'hFFFF_FFFD, "model_div_neg",
              ref_div(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check(ref_div(OP_REM, 32'hFFFF_FFF9, 32'd2) == 32'hFFFF_FFFF, "model_rem_neg",
              ref_div(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check(ref_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF) == 32'h8000_0000, "model_ovf",
              ref_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        // Directed cases.
        run_op(OP_DIVU, 32'd100, 32'd7, 0);
        run_op(OP_REMU, 32'd100, 32'd7, 0);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 0);
        run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 0);
        run_op(OP_DIVU, 32'h1234, 32'd0, 0);
        run_op(OP_REM,  32'h1234, 32'd0, 0);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5);
        run_op(OP_REMU, 32'hDEAD_BEEF, 32'd3, 0);

        // Flush during CALC: back to IDLE next edge, no response ever produced.
        exp_cur = 32'hFFFF_FFFF;
        @(negedge clk);
        saw_valid = 1'b0;
        in_valid = 1'b1; div_op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check(in_ready && !busy && !out_valid, "flush_idle", {29'd0, in_ready, busy, out_valid}, 32'd4);
        repeat (40) @(posedge clk);
        #1;
        check(saw_valid == 1'b0, "flush_no_valid", 32'(saw_valid), 32'd0);

        // A request presented together with flush is ignored.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; div_op = OP_DIVU; dividend = 32'd9; divisor = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check(in_ready && !busy, "flush_blocks_accept", {30'd0, in_ready, busy}, 32'd2);

        // Async reset mid-CALC clears outputs without a clock edge.
        @(negedge clk);
        in_valid = 1'b1; div_op = OP_DIV; dividend = 32'd12345; divisor = 32'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check(in_ready && !busy && !out_valid, "async_rst_flags", {29'd0, in_ready, busy, out_valid}, 32'd4);
        check(result == '0, "async_rst_result", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Async reset mid-DONE.
        run_op(OP_REMU, 32'd55, 32'd0, 0);
        exp_cur = ref_div(OP_DIVU, 32'd77, 32'd0);
        @(negedge clk);
        in_valid = 1'b1; div_op = OP_DIVU; dividend = 32'd77; divisor = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check(out_valid == 1'b1, "done_before_rst", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check(!out_valid && in_ready && result == '0, "async_rst_done", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Randomized operations with corner-biased operands and random backpressure.
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 16));
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                5: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
